pipe_stage_buf: RTL and testbench

- Parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, ...).
- Replaces the fixed 16-bit write-enable/clear register with a 2-entry skid buffer and a valid/ready handshake on both sides.
- Supports a flush that injects a configurable bubble instruction.
- Provides a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_stage_buf.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline stage register built as a 2-entry skid buffer.
//
// It sits on an inter-stage boundary (IF/ID, ID/EX, ...) and carries an
// instruction and its PC. Both sides use a valid/ready handshake. A flush
// discards everything that is buffered. A saturating counter records stall
// cycles for performance monitoring.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds its payload stable while valid=1 and ready=0.
// in_ready is computed only from registered occupancy, flush and rst, so it
// has no path from out_ready. out_* come straight from registers, so there
// is no combinational path from in_* to out_*.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous active-high reset (takes priority over flush)
//   flush        synchronous discard of all buffered entries
//   in_valid     upstream offers in_instr/in_pc
//   in_ready     stage can accept this cycle
//   in_instr     instruction from upstream
//   in_pc        PC of in_instr
//   out_valid    out_instr/out_pc hold a real entry
//   out_ready    downstream consumes this cycle
//   out_instr    head instruction, NOP_INSTR when empty
//   out_pc       head PC, 0 when empty
//   stall_count  saturating count of cycles with out_valid=1, out_ready=0
//   dbg_state    current occupancy state (0 EMPTY, 1 ONE, 2 TWO)
module pipe_stage_buf #(
    parameter int                 INSTR_W   = 16,
    parameter int                 ADDR_W    = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h1000,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [CNT_W-1:0]   stall_count,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [INSTR_W-1:0]   r_main_instr;
    logic [ADDR_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0]   r_skid_instr;
    logic [ADDR_W-1:0]    r_skid_pc;
    logic [INSTR_W-1:0]   w_main_instr_nxt;
    logic [ADDR_W-1:0]    w_main_pc_nxt;
    logic [INSTR_W-1:0]   w_skid_instr_nxt;
    logic [ADDR_W-1:0]    w_skid_pc_nxt;
    logic [CNT_W-1:0]     r_stall_count;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_drain;

    assign w_in_ready  = (r_state != TWO) && !flush && !rst;
    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = in_valid && w_in_ready;
    assign w_drain     = w_out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_instr_nxt = r_main_instr;
        w_main_pc_nxt    = r_main_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;
        if (rst || flush) begin
            // A drain in this cycle still reaches downstream; internal state is discarded.
            w_state_nxt      = EMPTY;
            w_main_instr_nxt = NOP_INSTR;
            w_main_pc_nxt    = '0;
            w_skid_instr_nxt = NOP_INSTR;
            w_skid_pc_nxt    = '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt      = ONE;
                        w_main_instr_nxt = in_instr;
                        w_main_pc_nxt    = in_pc;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_instr_nxt = in_instr;
                        w_main_pc_nxt    = in_pc;
                    end else if (w_accept) begin
                        // The head is still waiting, so the new entry parks behind it.
                        w_state_nxt      = TWO;
                        w_skid_instr_nxt = in_instr;
                        w_skid_pc_nxt    = in_pc;
                    end else if (w_drain) begin
                        w_state_nxt      = EMPTY;
                        w_main_instr_nxt = NOP_INSTR;
                        w_main_pc_nxt    = '0;
                    end
                end
                TWO: begin
                    // in_ready is low here, so the only possible event is a drain.
                    if (w_drain) begin
                        w_state_nxt      = ONE;
                        w_main_instr_nxt = r_skid_instr;
                        w_main_pc_nxt    = r_skid_pc;
                        w_skid_instr_nxt = NOP_INSTR;
                        w_skid_pc_nxt    = '0;
                    end
                end
                default: begin
                    w_state_nxt      = EMPTY;
                    w_main_instr_nxt = NOP_INSTR;
                    w_main_pc_nxt    = '0;
                    w_skid_instr_nxt = NOP_INSTR;
                    w_skid_pc_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
        r_main_instr <= w_main_instr_nxt;
        r_main_pc    <= w_main_pc_nxt;
        r_skid_instr <= w_skid_instr_nxt;
        r_skid_pc    <= w_skid_pc_nxt;
    end

    // Flush leaves the counter alone; only rst clears it. Saturates, never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign out_instr   = w_out_valid ? r_main_instr : NOP_INSTR;
    assign out_pc      = w_out_valid ? r_main_pc : '0;
    assign stall_count = r_stall_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] stall_count;
    logic [1:0]  dbg_state;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_instr;
    logic [15:0] s_out_pc;
    logic [3:0]  s_stall_count;
    logic [1:0]  s_dbg_state;

    int checks;
    int errors;

    pipe_stage_buf u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .stall_count (stall_count),
        .dbg_state   (dbg_state)
    );

    // Narrow-counter copy for the saturation sequence; shares all inputs.
    pipe_stage_buf #(.CNT_W(4)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .out_instr   (s_out_instr),
        .out_pc      (s_out_pc),
        .stall_count (s_stall_count),
        .dbg_state   (s_dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected during that cycle,
    // before the rising edge that applies it.
    typedef struct {
        logic        rst;
        logic        flush;
        logic        in_valid;
        logic [15:0] in_instr;
        logic [15:0] in_pc;
        logic        out_ready;
        logic        exp_out_valid;
        logic [15:0] exp_out_instr;
        logic [15:0] exp_out_pc;
        logic        exp_in_ready;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic iv,
                       input logic [15:0] ii, input logic [15:0] ip, input logic ordy,
                       input logic eov, input logic [15:0] eoi, input logic [15:0] eop,
                       input logic eir, input logic [15:0] est);
        vec_t v;
        v.rst = r; v.flush = f; v.in_valid = iv; v.in_instr = ii; v.in_pc = ip;
        v.out_ready = ordy; v.exp_out_valid = eov; v.exp_out_instr = eoi;
        v.exp_out_pc = eop; v.exp_in_ready = eir; v.exp_stall = est;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Driver: change inputs just after the rising edge.
    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [15:0] ii, input logic [15:0] ip, input logic ordy);
        @(posedge clk);
        #1;
        rst = r; flush = f; in_valid = iv; in_instr = ii; in_pc = ip; out_ready = ordy;
    endtask

    localparam logic [15:0] NOP = 16'h1000;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

        // Reset held for two cycles
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", {16'd0, out_instr}, {16'd0, NOP});
        chk("rst_out_pc",    {16'd0, out_pc}, 32'd0);
        chk("rst_stall",     {16'd0, stall_count}, 32'd0);
        chk("rst_in_ready_during_rst", {31'd0, in_ready}, 32'd0);

        //   rst flush iv instr     pc        ordy | ov  instr     pc        ir  stall
        // Streaming
        add(0, 0, 1, 16'hA001, 16'h0000, 1,   0, NOP,      16'h0000, 1, 0);
        add(0, 0, 1, 16'hA002, 16'h0002, 1,   1, 16'hA001, 16'h0000, 1, 0);
        add(0, 0, 1, 16'hA003, 16'h0004, 1,   1, 16'hA002, 16'h0002, 1, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 1,   1, 16'hA003, 16'h0004, 1, 0);
        // Backpressure into the skid entry, then release
        add(0, 0, 1, 16'hA001, 16'h0000, 0,   0, NOP,      16'h0000, 1, 0);
        add(0, 0, 1, 16'hA002, 16'h0002, 0,   1, 16'hA001, 16'h0000, 1, 0);
        add(0, 0, 1, 16'hA003, 16'h0004, 0,   1, 16'hA001, 16'h0000, 0, 1);
        add(0, 0, 1, 16'hA003, 16'h0004, 0,   1, 16'hA001, 16'h0000, 0, 2);
        add(0, 0, 1, 16'hA003, 16'h0004, 1,   1, 16'hA001, 16'h0000, 0, 3);
        add(0, 0, 1, 16'hA003, 16'h0004, 1,   1, 16'hA002, 16'h0002, 1, 3);
        add(0, 0, 0, 16'h0000, 16'h0000, 1,   1, 16'hA003, 16'h0004, 1, 3);
        add(0, 0, 0, 16'h0000, 16'h0000, 1,   0, NOP,      16'h0000, 1, 3);
        // Flush while full; drain in the flush cycle keeps the counter still
        add(0, 0, 1, 16'hB001, 16'h0010, 0,   0, NOP,      16'h0000, 1, 3);
        add(0, 0, 1, 16'hB002, 16'h0012, 0,   1, 16'hB001, 16'h0010, 1, 3);
        add(0, 1, 1, 16'hB003, 16'h0014, 1,   1, 16'hB001, 16'h0010, 0, 4);
        add(0, 0, 0, 16'h0000, 16'h0000, 1,   0, NOP,      16'h0000, 1, 4);
        // Flush and rst together while full
        add(0, 0, 1, 16'hC001, 16'h0020, 0,   0, NOP,      16'h0000, 1, 4);
        add(0, 0, 1, 16'hC002, 16'h0022, 0,   1, 16'hC001, 16'h0020, 1, 4);
        add(1, 1, 1, 16'hC003, 16'h0024, 0,   1, 16'hC001, 16'h0020, 0, 5);
        add(0, 0, 0, 16'h0000, 16'h0000, 0,   0, NOP,      16'h0000, 1, 0);
        // rst alone with two entries buffered, then a fresh accept
        add(0, 0, 1, 16'hD001, 16'h0030, 0,   0, NOP,      16'h0000, 1, 0);
        add(0, 0, 1, 16'hD002, 16'h0032, 0,   1, 16'hD001, 16'h0030, 1, 0);
        add(1, 0, 0, 16'h0000, 16'h0000, 0,   1, 16'hD001, 16'h0030, 0, 1);
        add(0, 0, 1, 16'hD003, 16'h0034, 1,   0, NOP,      16'h0000, 1, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 1,   1, 16'hD003, 16'h0034, 1, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 1,   0, NOP,      16'h0000, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].in_valid,
                  vecs[i].in_instr, vecs[i].in_pc, vecs[i].out_ready);
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_out_valid});
            chk($sformatf("v%0d_out_instr", i), {16'd0, out_instr}, {16'd0, vecs[i].exp_out_instr});
            chk($sformatf("v%0d_out_pc", i),    {16'd0, out_pc},    {16'd0, vecs[i].exp_out_pc});
            chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].exp_in_ready});
            chk($sformatf("v%0d_stall", i),     {16'd0, stall_count}, {16'd0, vecs[i].exp_stall});
        end

        // Saturation: reset, load one entry, then hold out_ready=0 for 20+ cycles.
        drive(1, 0, 0, 16'h0000, 16'h0000, 0);
        drive(0, 0, 1, 16'hE001, 16'h0040, 0);
        @(negedge clk);
        chk("sat_load_stall", {28'd0, s_stall_count}, 32'd0);
        drive(0, 0, 0, 16'h0000, 16'h0000, 0);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("sat_k%0d_stall4", k), {28'd0, s_stall_count}, (k > 15) ? 32'd15 : k);
            chk($sformatf("sat_k%0d_stall16", k), {16'd0, stall_count}, k);
            chk($sformatf("sat_k%0d_hold_instr", k), {16'd0, s_out_instr}, 32'h0000E001);
            @(posedge clk);
        end
        // Flush does not clear a saturated counter.
        drive(0, 1, 0, 16'h0000, 16'h0000, 1);
        drive(0, 0, 0, 16'h0000, 16'h0000, 1);
        @(negedge clk);
        chk("sat_after_flush_stall4", {28'd0, s_stall_count}, 32'd15);
        chk("sat_after_flush_valid", {31'd0, s_out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
